vga_scan_scheduler: RTL

VGA_SCAN_SCHEDULER -- requirements
Module: vga_scan_scheduler

---
 rtl/vga_scan_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vga_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_scheduler
// Purpose  : VGA raster timing with a per-line sprite fetch request scheduler
//            and a sticky underrun flag for late line-buffer loads.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_scheduler #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_ack,
    input  logic       underrun_clr,
    output logic       pix_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start,
    output logic       fetch_req,
    output logic [9:0] fetch_line,
    output logic       underrun
);

    localparam int         c_H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [3:0] c_DIV_LAST     = 4'(CLK_DIV - 1);
    localparam logic [9:0] c_H_LAST       = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST       = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACTIVE     = 10'(H_ACTIVE);
    localparam logic [9:0] c_H_ACT_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] c_V_ACTIVE     = 10'(V_ACTIVE);
    localparam logic [9:0] c_H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } fetch_state_t;

    fetch_state_t state_q, state_d;
    logic [3:0]   div_cnt_q, div_cnt_d;
    logic [9:0]   hcount_q, hcount_d;
    logic [9:0]   vcount_q, vcount_d;
    logic [9:0]   fetch_line_q, fetch_line_d;
    logic         underrun_q, underrun_d;
    logic         frame_start_q, frame_start_d;

    logic         w_tick;
    logic         w_line_end;
    logic         w_underrun_set;
    logic [9:0]   w_next_line;

    always_comb begin
        w_tick         = (div_cnt_q == c_DIV_LAST);
        w_line_end     = w_tick && (hcount_q == c_H_LAST);
        w_next_line    = (vcount_q == c_V_LAST) ? 10'd0 : vcount_q + 10'd1;
        w_underrun_set = 1'b0;

        div_cnt_d     = w_tick ? 4'd0 : div_cnt_q + 4'd1;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        state_d       = state_q;
        fetch_line_d  = fetch_line_q;
        frame_start_d = w_line_end && (vcount_q == c_V_LAST);

        if (w_tick) begin
            if (w_line_end) begin
                hcount_d = 10'd0;
                vcount_d = w_next_line;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        // The fetch for the next line is launched at the end of the current
        // line's active region and must be accepted before that line wraps.
        case (state_q)
            S_IDLE: begin
                if (w_tick && (hcount_q == c_H_ACT_LAST) && (w_next_line < c_V_ACTIVE)) begin
                    state_d      = S_REQ;
                    fetch_line_d = w_next_line;
                end
            end
            S_REQ: begin
                if (fetch_ack) begin
                    state_d = S_IDLE;
                end else if (w_line_end) begin
                    state_d        = S_IDLE;
                    w_underrun_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            div_cnt_q     <= 4'd0;
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            fetch_line_q  <= 10'd0;
            underrun_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            fetch_line_q  <= fetch_line_d;
            underrun_q    <= underrun_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_tick    = w_tick;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = !((hcount_q >= c_H_SYNC_START) && (hcount_q < c_H_SYNC_END));
    assign vsync       = !((vcount_q >= c_V_SYNC_START) && (vcount_q < c_V_SYNC_END));
    assign video_on    = (hcount_q < c_H_ACTIVE) && (vcount_q < c_V_ACTIVE);
    assign frame_start = frame_start_q;
    assign fetch_req   = (state_q == S_REQ);
    assign fetch_line  = fetch_line_q;
    assign underrun    = underrun_q;

endmodule
`default_nettype wire
